// File: rtl/dem_pn_seq_gen.sv
// PN bit source for the DEM switching-block tree: Galois LFSR with seed load,
// fixed warm-up before valid, and recovery from the all-zero lock-up state.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_WARMUP | LFSR free-runs every cycle, pn_valid_o low, warm_cnt counts
//   ST_RUN    | LFSR advances only on en_i, pn_valid_o high
module dem_pn_seq_gen #(
  parameter int                    LFSR_WIDTH    = 16,
  parameter int                    NUM_BLOCKS    = 7,
  parameter logic [LFSR_WIDTH-1:0] POLY          = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] SEED          = 16'hACE1,
  parameter int                    STRIDE        = 2,
  parameter int                    WARMUP_CYCLES = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  en_i,
  input  logic                  seed_load_i,
  input  logic [LFSR_WIDTH-1:0] seed_i,
  output logic [NUM_BLOCKS-1:0] pn_seq_o,
  output logic                  pn_valid_o,
  output logic                  seed_err_o
);

  localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [7:0]            warm_cnt_q, warm_cnt_d;
  logic                  seed_err_q, seed_err_d;
  logic [NUM_BLOCKS-1:0] pn_seq_q, pn_nxt, pn_rst;

  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);

  // Tap map is evaluated on the next LFSR value so pn_seq_o moves on the same edge.
  for (genvar j = 0; j < NUM_BLOCKS; j++) begin : g_map
    assign pn_nxt[j] = lfsr_d[(j * STRIDE) % LFSR_WIDTH];
    assign pn_rst[j] = SEED[(j * STRIDE) % LFSR_WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    warm_cnt_d = warm_cnt_q;
    seed_err_d = seed_err_q;
    if (seed_load_i) begin
      lfsr_d     = (seed_i == '0) ? SEED : seed_i;
      warm_cnt_d = '0;
      state_d    = ST_WARMUP;
      seed_err_d = (seed_i == '0);
    end else if (lfsr_q == '0) begin
      lfsr_d     = SEED;
      warm_cnt_d = '0;
      state_d    = ST_WARMUP;
      seed_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          lfsr_d     = lfsr_step;
          warm_cnt_d = warm_cnt_q + 8'd1;
          if (warm_cnt_q == WARM_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (en_i) lfsr_d = lfsr_step;
        end
        default: state_d = ST_WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_WARMUP;
      lfsr_q     <= SEED;
      warm_cnt_q <= '0;
      seed_err_q <= 1'b0;
      pn_seq_q   <= pn_rst;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      warm_cnt_q <= warm_cnt_d;
      seed_err_q <= seed_err_d;
      pn_seq_q   <= pn_nxt;
    end
  end

  assign pn_seq_o   = pn_seq_q;
  assign pn_valid_o = (state_q == ST_RUN);
  assign seed_err_o = seed_err_q;

endmodule

// File: tb/tb_dem_pn_seq_gen.sv
// Bench for dem_pn_seq_gen: directed scenarios plus random traffic against a
// behavioural model (warm-up as remaining-steps count, LFSR as plain integer math).
module tb_dem_pn_seq_gen;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        en_i;
  logic        seed_load_i;
  logic [15:0] seed_i;
  logic [6:0]  pn_seq_o;
  logic        pn_valid_o;
  logic        seed_err_o;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int unsigned m_lfsr;
  int          m_warm_left;
  bit          m_err;

  dem_pn_seq_gen dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .en_i        (en_i),
    .seed_load_i (seed_load_i),
    .seed_i      (seed_i),
    .pn_seq_o    (pn_seq_o),
    .pn_valid_o  (pn_valid_o),
    .seed_err_o  (seed_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [6:0] exp_map(input int unsigned s);
    logic [6:0] r;
    for (int j = 0; j < 7; j++) r[j] = 1'((s >> ((j * 2) % 16)) & 1);
    return r;
  endfunction

  function automatic int unsigned model_step(input int unsigned s);
    return (s % 2 == 1) ? ((s / 2) ^ 32'hB400) : (s / 2);
  endfunction

  task automatic model_reset();
    m_lfsr = 32'hACE1; m_warm_left = 3; m_err = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit ld, input int unsigned sd);
    if (ld) begin
      m_lfsr = (sd == 0) ? 32'hACE1 : sd;
      m_warm_left = 3;
      m_err = (sd == 0);
    end else if (m_lfsr == 0) begin
      m_lfsr = 32'hACE1; m_warm_left = 3; m_err = 1'b1;
    end else if (m_warm_left > 0) begin
      m_lfsr = model_step(m_lfsr); m_warm_left--;
    end else if (en) begin
      m_lfsr = model_step(m_lfsr);
    end
  endtask

  // drive inputs, take one edge, advance the model, settle past the edge
  task automatic tick(input bit en, input bit ld, input logic [15:0] sd);
    en_i = en; seed_load_i = ld; seed_i = sd;
    @(posedge clk_i);
    model_edge(en, ld, sd);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_seq [3] = '{16'hE270, 16'h7138, 16'h389C};
    n_vec++;
    if (pn_seq_o !== 7'h29 || pn_valid_o !== 1'b0 || seed_err_o !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: got pn=%h v=%b e=%b want pn=29 v=0 e=0", pn_seq_o, pn_valid_o, seed_err_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 16'h0);
      n_vec++;
      if (dut.lfsr_q !== exp_seq[i] || pn_valid_o !== (i == 2)) begin
        n_err++; $display("FAIL warmup_edge%0d: got lfsr=%h v=%b want lfsr=%h v=%b", i + 1, dut.lfsr_q, pn_valid_o, exp_seq[i], i == 2);
      end
    end
    n_vec++;
    if (pn_seq_o !== 7'h46) begin
      n_err++; $display("FAIL warmup_pn: got %h want 46", pn_seq_o);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 16'h0);
      n_vec++;
      if (dut.lfsr_q !== 16'h389C || pn_seq_o !== 7'h46 || pn_valid_o !== 1'b1) begin
        n_err++; $display("FAIL hold_en0: got lfsr=%h pn=%h v=%b want 389c 46 1", dut.lfsr_q, pn_seq_o, pn_valid_o);
      end
    end
  endtask

  task automatic test_run_enable();
    bit          ens  [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] exps [3] = '{16'h1C4E, 16'h1C4E, 16'h0E27};
    for (int i = 0; i < 3; i++) begin
      tick(ens[i], 1'b0, 16'h0);
      n_vec++;
      if (dut.lfsr_q !== exps[i] || pn_seq_o !== exp_map(exps[i]) || pn_valid_o !== 1'b1) begin
        n_err++; $display("FAIL run_en step%0d: got lfsr=%h pn=%h v=%b want %h %h 1", i, dut.lfsr_q, pn_seq_o, pn_valid_o, exps[i], exp_map(exps[i]));
      end
    end
  endtask

  task automatic test_zero_seed();
    tick(1'b1, 1'b1, 16'h0000);
    n_vec++;
    if (dut.lfsr_q !== 16'hACE1 || pn_valid_o !== 1'b0 || seed_err_o !== 1'b1 || pn_seq_o !== 7'h29) begin
      n_err++; $display("FAIL zero_seed: got lfsr=%h v=%b e=%b pn=%h want ace1 0 1 29", dut.lfsr_q, pn_valid_o, seed_err_o, pn_seq_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 16'h0);
      n_vec++;
      if (pn_valid_o !== (i == 2) || seed_err_o !== 1'b1) begin
        n_err++; $display("FAIL zero_seed_warm%0d: got v=%b e=%b want v=%b e=1", i, pn_valid_o, seed_err_o, i == 2);
      end
    end
  endtask

  task automatic test_seed_restart();
    tick(1'b0, 1'b1, 16'h1234);
    n_vec++;
    if (dut.lfsr_q !== 16'h1234 || seed_err_o !== 1'b0 || pn_valid_o !== 1'b0) begin
      n_err++; $display("FAIL seed_load: got lfsr=%h e=%b v=%b want 1234 0 0", dut.lfsr_q, seed_err_o, pn_valid_o);
    end
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 16'h1234);
    n_vec++;
    if (dut.lfsr_q !== 16'h1234 || pn_valid_o !== 1'b0) begin
      n_err++; $display("FAIL reload_mid_warm: got lfsr=%h v=%b want 1234 0", dut.lfsr_q, pn_valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 16'h0);
      n_vec++;
      if (pn_valid_o !== (i == 2) || dut.lfsr_q !== 16'(m_lfsr)) begin
        n_err++; $display("FAIL restart_warm%0d: got v=%b lfsr=%h want v=%b lfsr=%h", i, pn_valid_o, dut.lfsr_q, i == 2, 16'(m_lfsr));
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 16'hBEEF);
      n_vec++;
      if (dut.lfsr_q !== 16'hBEEF || pn_valid_o !== 1'b0) begin
        n_err++; $display("FAIL load_held%0d: got lfsr=%h v=%b want beef 0", i, dut.lfsr_q, pn_valid_o);
      end
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_lockup();
    @(negedge clk_i);
    force dut.lfsr_q = 16'h0000;
    #1;
    release dut.lfsr_q;
    m_lfsr = 0;
    tick(1'b1, 1'b0, 16'h0);
    n_vec++;
    if (dut.lfsr_q !== 16'hACE1 || pn_valid_o !== 1'b0 || seed_err_o !== 1'b1 || pn_seq_o !== 7'h29) begin
      n_err++; $display("FAIL lockup: got lfsr=%h v=%b e=%b pn=%h want ace1 0 1 29", dut.lfsr_q, pn_valid_o, seed_err_o, pn_seq_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 16'h0);
      n_vec++;
      if (pn_valid_o !== (i == 2) || dut.lfsr_q !== 16'(m_lfsr)) begin
        n_err++; $display("FAIL lockup_warm%0d: got v=%b lfsr=%h want v=%b lfsr=%h", i, pn_valid_o, dut.lfsr_q, i == 2, 16'(m_lfsr));
      end
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 1'b0, 16'h0);
    #2;
    reset_ni = 1'b0;
    #1;
    n_vec++;
    if (pn_seq_o !== 7'h29 || pn_valid_o !== 1'b0 || seed_err_o !== 1'b0 || dut.lfsr_q !== 16'hACE1) begin
      n_err++; $display("FAIL async_reset: got pn=%h v=%b e=%b lfsr=%h want 29 0 0 ace1", pn_seq_o, pn_valid_o, seed_err_o, dut.lfsr_q);
    end
    #1;
    reset_ni = 1'b1;
    model_reset();
    test_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bit          en = 1'($urandom_range(0, 1));
      bit          ld = ($urandom_range(0, 15) == 0);
      logic [15:0] sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      tick(en, ld, sd);
      n_vec++;
      if (dut.lfsr_q !== 16'(m_lfsr) || pn_seq_o !== exp_map(m_lfsr) ||
          pn_valid_o !== (m_warm_left == 0) || seed_err_o !== m_err) begin
        n_err++; $display("FAIL random%0d: got lfsr=%h pn=%h v=%b e=%b want %h %h %b %b", i, dut.lfsr_q, pn_seq_o, pn_valid_o, seed_err_o, 16'(m_lfsr), exp_map(m_lfsr), m_warm_left == 0, m_err);
      end
    end
  endtask

  initial begin
    reset_ni = 1'b0; en_i = 1'b0; seed_load_i = 1'b0; seed_i = '0;
    model_reset();
    #12;
    reset_ni = 1'b1;
    test_reset();
    test_run_enable();
    test_zero_seed();
    test_seed_restart();
    test_lockup();
    test_async_reset();
    test_run_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
